// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: op codes, FSM states and op decode.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROR  = 3'b100
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  // Map the raw op field onto the enum; reserved codes 101-111 act as pass.
  function automatic shift_op_t decode_op(input logic [2:0] code);
    case (code)
      3'b001:  return OP_LSL;
      3'b010:  return OP_LSR;
      3'b011:  return OP_ASR;
      3'b100:  return OP_ROR;
      default: return OP_PASS;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shift the working word by k (0..STEP) positions
// and report the last bit pushed out, which becomes carry on the final step.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  shift_op_t        op,
  input  logic [KW-1:0]    k,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] res,
  output logic             bit_out
);

  logic lsb_out;  // data[k-1]: last bit leaving the LSB end
  logic msb_out;  // data[WIDTH-k]: last bit leaving the MSB end

  // Select the bit that leaves the word for a k-position move (k=0 gives 0).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    lsb_out = 1'b0;
    msb_out = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (k == KW'(i + 1)) begin
        lsb_out = data[i];
        msb_out = data[WIDTH-1-i];
      end
    end
  end

  // Shift network for the four real operations; anything else passes through.
  always_comb begin
    res     = data;
    bit_out = 1'b0;
    case (op)
      OP_LSL: begin
        res     = data << k;
        bit_out = msb_out;
      end
      OP_LSR: begin
        res     = data >> k;
        bit_out = lsb_out;
      end
      OP_ASR: begin
        res     = WIDTH'($signed(data) >>> k);
        bit_out = lsb_out;
      end
      OP_ROR: begin
        // A left shift by WIDTH yields zero, so k=0 degenerates to a pass.
        res     = (data >> k) | (data << (WIDTH - int'(k)));
        bit_out = lsb_out;
      end
      default: begin
        res     = data;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: accepts an operand under start/ready, shifts it up to
// STEP positions per clock, then pulses done with the result and carry-out.
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             carry
);

  localparam int KW = $clog2(STEP + 1);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  shift_op_t        op_q, op_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic             carry_q, carry_d;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_res;
  logic             step_bit;

  // Positions to move this cycle: the smaller of the remaining count and STEP.
  assign k = (rem_q >= AW'(STEP)) ? KW'(STEP) : KW'(rem_q);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .op      (op_q),
    .k       (k),
    .data    (work_q),
    .res     (step_res),
    .bit_out (step_bit)
  );

  // Next-state and datapath decisions for IDLE -> (SHIFT ->) DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    sout_d  = sout_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (decode_op(op) == OP_PASS || amt == '0) begin
            sout_d  = in;
            carry_d = 1'b0;
            state_d = DONE;
          end else begin
            work_d  = in;
            op_d    = decode_op(op);
            rem_d   = amt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_res;
        rem_d  = rem_q - AW'(k);
        // Final step: publish the result together with the last bit out.
        if (rem_q == AW'(k)) begin
          sout_d  = step_res;
          carry_d = step_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and visible outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= IDLE;
      sout_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

  // Working datapath registers, loaded on accept and consumed only in SHIFT.
  always_ff @(posedge clk) begin
    // NOTE: these carry no reset; SHIFT is only reachable through an accept
    // that loads all three, so their power-up contents are never observed.
    work_q <= work_d;
    op_q   <= op_d;
    rem_q  <= rem_d;
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sout  = sout_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: one STEP=1 and one STEP=4 instance share
// stimulus; expected results and completion cycles are queued at accept and
// popped by per-instance monitors on each done pulse.
module tb_iter_shifter;

  localparam int W = 16;

  typedef struct {
    string       name;
    logic [15:0] sout;
    logic        carry;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [3:0]  amt = 4'd0;
  logic [15:0] din = 16'h0000;

  logic        ready1, done1, carry1;
  logic [15:0] sout1;
  logic        ready4, done4, carry4;
  logic [15:0] sout4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iter_shifter #(.WIDTH(W), .STEP(1)) u_s1 (
    .clk (clk), .reset (rst), .start (start), .op (op), .amt (amt), .in (din),
    .ready (ready1), .done (done1), .sout (sout1), .carry (carry1)
  );

  iter_shifter #(.WIDTH(W), .STEP(4)) u_s4 (
    .clk (clk), .reset (rst), .start (start), .op (op), .amt (amt), .in (din),
    .ready (ready4), .done (done4), .sout (sout4), .carry (carry4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int calc_n(input logic [2:0] o, input logic [3:0] a, input int step);
    if (o == 3'b000 || o >= 3'b101 || a == 4'd0) return 0;
    return (int'(a) + step - 1) / step;
  endfunction

  // Monitor for the STEP=1 instance.
  always @(negedge clk) begin
    if (done1) begin
      check("s1 done_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        check($sformatf("s1 %s sout", e.name), 32'(sout1), 32'(e.sout));
        check($sformatf("s1 %s carry", e.name), 32'(carry1), 32'(e.carry));
        check($sformatf("s1 %s latency", e.name), 32'(cyc), 32'(e.due));
      end
    end
  end

  // Monitor for the STEP=4 instance.
  always @(negedge clk) begin
    if (done4) begin
      check("s4 done_pending", 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
        exp_t e;
        e = q4.pop_front();
        check($sformatf("s4 %s sout", e.name), 32'(sout4), 32'(e.sout));
        check($sformatf("s4 %s carry", e.name), 32'(carry4), 32'(e.carry));
        check($sformatf("s4 %s latency", e.name), 32'(cyc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; returns at a negedge with both instances idle.
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (ready1 && ready4) break;
      @(negedge clk);
    end
    check("wait_idle", 32'(ready1 && ready4), 32'd1);
  endtask

  task automatic issue(input string name, input logic [2:0] o, input logic [3:0] a,
                       input logic [15:0] d, input logic [15:0] es, input logic ec,
                       input bit push);
    exp_t e;
    wait_idle();
    op    = o;
    amt   = a;
    din   = d;
    start = 1'b1;
    @(posedge clk);
    // cyc still holds its pre-edge value here; the accept edge makes it cyc+1.
    if (push) begin
      e.name  = name;
      e.sout  = es;
      e.carry = ec;
      e.due   = cyc + 1 + calc_n(o, a, 1);
      q1.push_back(e);
      e.due   = cyc + 1 + calc_n(o, a, 4);
      q4.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("s1 %s ready_low", name), 32'(ready1), 32'd0);
    check($sformatf("s4 %s ready_low", name), 32'(ready4), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("s1 %s ready", tag), 32'(ready1), 32'd1);
    check($sformatf("s1 %s done", tag),  32'(done1),  32'd0);
    check($sformatf("s1 %s sout", tag),  32'(sout1),  32'd0);
    check($sformatf("s1 %s carry", tag), 32'(carry1), 32'd0);
    check($sformatf("s4 %s ready", tag), 32'(ready4), 32'd1);
    check($sformatf("s4 %s done", tag),  32'(done4),  32'd0);
    check($sformatf("s4 %s sout", tag),  32'(sout4),  32'd0);
    check($sformatf("s4 %s carry", tag), 32'(carry4), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");

    // Directed vectors: op, amt, in -> expected sout, carry.
    issue("lsl15",     3'b001, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b1);
    issue("asr3",      3'b011, 4'd3,  16'h8004, 16'hF000, 1'b1, 1'b1);
    issue("lsr8",      3'b010, 4'd8,  16'hFFFF, 16'h00FF, 1'b1, 1'b1);
    issue("ror4",      3'b100, 4'd4,  16'h00F1, 16'h100F, 1'b0, 1'b1);
    issue("ror9",      3'b100, 4'd9,  16'h00F1, 16'h7880, 1'b0, 1'b1);
    issue("ror1",      3'b100, 4'd1,  16'h0001, 16'h8000, 1'b1, 1'b1);
    issue("pass",      3'b000, 4'd5,  16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    issue("lsl0",      3'b001, 4'd0,  16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    issue("op111",     3'b111, 4'd7,  16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    issue("op101",     3'b101, 4'd3,  16'h1234, 16'h1234, 1'b0, 1'b1);
    issue("lsl1",      3'b001, 4'd1,  16'h8001, 16'h0002, 1'b1, 1'b1);
    issue("asr15pos",  3'b011, 4'd15, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    issue("asr15neg",  3'b011, 4'd15, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
    issue("lsr15",     3'b010, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b1);
    issue("lsl4",      3'b001, 4'd4,  16'h1234, 16'h2340, 1'b1, 1'b1);
    issue("ror15",     3'b100, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b1);
    issue("asr5",      3'b011, 4'd5,  16'hA5A5, 16'hFD2D, 1'b0, 1'b1);

    // start and new operands while busy must be ignored.
    issue("busy_start", 3'b001, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b1);
    op    = 3'b010;
    amt   = 4'd2;
    din   = 16'hFFFF;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of SHIFT: no done, outputs back to reset values.
    issue("abort", 3'b001, 4'd15, 16'h0001, 16'h8000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("abort");
    repeat (20) @(negedge clk);

    // Reset together with start: the request must not be taken.
    op    = 3'b001;
    amt   = 4'd3;
    din   = 16'h00FF;
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_reset_values("rst_start");
    repeat (8) @(negedge clk);

    // A fresh operation completes normally after the aborts.
    issue("after_reset", 3'b010, 4'd9, 16'hF000, 16'h0078, 1'b0, 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);

    check("s1 queue_drained", 32'(q1.size()), 32'd0);
    check("s4 queue_drained", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
